fifo_burst_reader: RTL
======================

# fifo_burst_reader

Read-side companion to the team's synchronous FIFO. Drains a first-word-fall-through FIFO read port and emits fixed-length bursts on an AXI-Stream master, marking the last beat of each burst with tlast. Sits between a command or pixel FIFO and a burst-oriented consumer such as a DMA write channel. Partial bursts are emitted on an explicit flush request or after an idle timeout.

## Interface
- BW, 8: data width; must equal the FIFO BW.
- LGFLEN, 4: log2 of the FIFO depth; i_fifo_fill is LGFLEN+1 bits.
- BURST_LEN, 8: full burst length in beats; legal range 1..2^LGFLEN.
- TIMEOUT, 16: IDLE cycles with a partial fill before an automatic flush; 0 disables the timeout.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_reset  in  1  synchronous, active-high reset.
- i_fifo_data  in  BW  FIFO head word; valid whenever i_fifo_empty=0.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_fill  in  LGFLEN+1  FIFO registered occupancy.
- o_fifo_rd  out  1  FIFO pop strobe; combinational.
- i_flush  in  1  single-cycle request to emit any partial data.
- m_axis_tvalid  out  1  output beat valid; registered.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  BW  output data; registered.
- m_axis_tlast  out  1  last beat of the burst; registered.
- o_busy  out  1  high when state=BURST or m_axis_tvalid=1.
- o_burst_count  out  16  count of completed bursts; wraps modulo 2^16.

## Operation
Output stage:
- Two-entry skid buffer made of a main register, which drives m_axis_*, and a skid register.
- A beat transfers when m_axis_tvalid && m_axis_tready.
- Internal accept = skid register empty.
- A popped word goes into the main register if the main register is empty or transferring this cycle; otherwise it goes into the skid register.
- The skid register moves to the main register on transfer.

Pop rule:
- o_fifo_rd = (state==BURST) && !i_fifo_empty && beats_left!=0 && accept.

State IDLE (evaluated each cycle):
- If i_fifo_fill >= BURST_LEN: go to BURST with beats_left=BURST_LEN.
- Else if (flush_pending || timer expired) && i_fifo_fill!=0: go to BURST with beats_left=i_fifo_fill.
- flush_pending is set by i_flush.
- flush_pending is cleared when a burst starts, or when i_fifo_fill==0 in IDLE.
- An i_flush received during BURST is held in flush_pending and applies at the next IDLE.
- timer increments while in IDLE with 0<fill<BURST_LEN; it is cleared otherwise or on burst start.
- The timer expires when timer==TIMEOUT-1 and TIMEOUT!=0.

State BURST:
- Each pop decrements beats_left.
- The pop with beats_left==1 loads tlast=1 with that word; all other popped words have tlast=0.
- The state returns to IDLE on the cycle after that pop.

Counters and reset:
- o_burst_count increments on each transfer with m_axis_tlast=1.
- Reset values: state IDLE; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0; o_busy=0; o_burst_count=0; skid empty; beats_left=0; timer=0; flush_pending=0.
- Reset mid-burst discards both skid-buffer entries. Unpopped words remain in the FIFO.

## Timing
- i_fifo_fill reaching BURST_LEN is sampled in cycle N. State=BURST and o_fifo_rd=1 in N+1. First m_axis_tvalid in N+2.
- With tready held high, throughput is 1 beat/cycle. There is exactly one bubble cycle (IDLE) between back-to-back bursts.
- tready low: at most one extra word is popped into the skid register, then o_fifo_rd drops. Pops resume the cycle after the skid register empties.
- m_axis_tvalid and m_axis_tdata hold stable while tvalid && !tready.
- Burst length is latched at burst start. Writes into the FIFO during a burst never lengthen it.
- i_fifo_empty during BURST (protocol violation) only gates o_fifo_rd; no state corruption occurs.
- beats_left is LGFLEN+1 bits. A burst of exactly 2^LGFLEN beats is legal.

## Test plan
- Write 8 words 0x10..0x17 with tready=1: beats 0x10..0x17 appear on cycles N+2..N+9, tlast only on 0x17, o_burst_count=1.
- Write 16 words with tready=1: two bursts of 8 beats with one idle bubble between them, tlast on beats 8 and 16, o_burst_count=2.
- Write 3 words, pulse i_flush: one 3-beat burst with tlast on beat 3; the FIFO ends empty.
- Write 5 words with no flush and TIMEOUT=16: the burst starts 16 IDLE cycles after fill becomes nonzero, 5 beats, tlast on beat 5.
- Full burst with tready toggling randomly: data order preserved, no beat dropped or duplicated, tdata and tlast stable while stalled, at most 1 word held in the skid register.
- Assert i_reset after the 4th beat of an 8-beat burst: the next cycle shows tvalid=0, o_busy=0, o_burst_count=0, and the 4 unpopped words are still in the FIFO.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Drains a first-word-fall-through FIFO and emits fixed-length AXI-Stream bursts with tlast.
// Partial bursts go out on a flush request or after an idle timeout.
module fifo_burst_reader #(
  parameter int unsigned BW        = 8,
  parameter int unsigned LGFLEN    = 4,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [BW-1:0]     i_fifo_data,
  input  logic              i_fifo_empty,
  input  logic [LGFLEN:0]   i_fifo_fill,
  output logic              o_fifo_rd,
  input  logic              i_flush,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [BW-1:0]     m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              o_busy,
  output logic [15:0]       o_burst_count
);

  localparam int unsigned   FW        = LGFLEN + 1;
  localparam int unsigned   TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] BurstLenW = FW'(BURST_LEN);
  localparam logic [FW-1:0] OneF      = FW'(1);
  localparam logic [TW-1:0] TimerMax  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] OneT      = TW'(1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q;
  logic [FW-1:0]   beats_left_q;
  logic [TW-1:0]   timer_q;
  logic            flush_pending_q;
  logic            skid_valid_q;
  logic [BW-1:0]   skid_data_q;
  logic            skid_last_q;

  logic accept;
  logic xfer;
  logic pop_last;
  logic fill_full;
  logic fill_any;
  logic timer_expired;

  assign accept        = !skid_valid_q;
  assign xfer          = m_axis_tvalid && m_axis_tready;
  // No pop during a reset cycle, so discarded beats are never taken out of the FIFO.
  assign o_fifo_rd     = (state_q == StBurst) && !i_fifo_empty && (beats_left_q != '0) &&
                         accept && !i_reset;
  assign pop_last      = o_fifo_rd && (beats_left_q == OneF);
  assign fill_full     = i_fifo_fill >= BurstLenW;
  assign fill_any      = i_fifo_fill != '0;
  assign timer_expired = (TIMEOUT != 0) && (timer_q == TimerMax);
  assign o_busy        = (state_q == StBurst) || m_axis_tvalid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q         <= StIdle;
      beats_left_q    <= '0;
      timer_q         <= '0;
      flush_pending_q <= 1'b0;
      skid_valid_q    <= 1'b0;
      skid_data_q     <= '0;
      skid_last_q     <= 1'b0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tlast    <= 1'b0;
      o_burst_count   <= '0;
    end else begin
      // Output skid buffer: drain main, refill from skid, then place any popped word.
      if (xfer) begin
        if (m_axis_tlast) o_burst_count <= o_burst_count + 16'd1;
        if (skid_valid_q) begin
          m_axis_tdata <= skid_data_q;
          m_axis_tlast <= skid_last_q;
          skid_valid_q <= 1'b0;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
      if (o_fifo_rd) begin
        if (!m_axis_tvalid || xfer) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= i_fifo_data;
          m_axis_tlast  <= pop_last;
        end else begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= i_fifo_data;
          skid_last_q  <= pop_last;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (fill_full) begin
            state_q         <= StBurst;
            beats_left_q    <= BurstLenW;
            timer_q         <= '0;
            flush_pending_q <= 1'b0;
          end else if ((flush_pending_q || timer_expired) && fill_any) begin
            state_q         <= StBurst;
            beats_left_q    <= i_fifo_fill;
            timer_q         <= '0;
            flush_pending_q <= 1'b0;
          end else if (fill_any) begin
            timer_q <= timer_q + OneT;
          end else begin
            timer_q         <= '0;
            flush_pending_q <= 1'b0;
          end
        end
        StBurst: begin
          timer_q <= '0;
          if (o_fifo_rd) beats_left_q <= beats_left_q - OneF;
          if (pop_last) state_q <= StIdle;
        end
      endcase

      // A flush arriving mid-burst is held until the next IDLE.
      if (i_flush) flush_pending_q <= 1'b1;
    end
  end

endmodule
